// File: rtl/pm_mem_resp.sv
// Program-memory responder: boot-loaded instruction array serving sequencer reads/writes.
// Reads return one cycle after the address; out-of-range accesses pulse pm_err.
module pm_mem_resp #(
    parameter int unsigned PM_DEPTH   = 256,
    parameter int unsigned BOOT_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps_pm_cslt,
    input  logic        ps_pm_wrb,
    input  logic [15:0] ps_pm_add,
    input  logic [31:0] ps_pm_dt,
    output logic [31:0] pm_ps_op,
    input  logic        bt_vld,
    input  logic [7:0]  bt_dt,
    output logic        bt_rdy,
    output logic        pm_boot_done,
    output logic        pm_err
);

    localparam int unsigned AW = (PM_DEPTH > 1) ? $clog2(PM_DEPTH) : 1;
    localparam int unsigned CW = $clog2(PM_DEPTH + 1);
    // Only meaningful when BOOT_WORDS > 0; the zero case never reaches the compare.
    localparam logic [CW-1:0] LAST_WORD = CW'(BOOT_WORDS - 1);

    typedef enum logic [0:0] {StBoot, StRun} state_t;

    state_t        state;
    logic [1:0]    byte_idx;
    logic [CW-1:0] word_count;
    logic [23:0]   asm_word;
    logic [31:0]   mem [PM_DEPTH];

    logic in_range;
    logic bt_take;
    logic boot_wr;
    logic seq_wr;

    // Full 16-bit compare: addresses never alias into the array.
    assign in_range = ({16'h0, ps_pm_add} < PM_DEPTH);
    assign bt_take  = (state == StBoot) && bt_rdy && bt_vld;
    assign boot_wr  = bt_take && (byte_idx == 2'd3);
    assign seq_wr   = (state == StRun) && ps_pm_cslt && ps_pm_wrb && in_range;

    // Array is deliberately outside the reset domain so its contents survive rst.
    always_ff @(posedge clk) begin
        if (boot_wr) begin
            mem[word_count[AW-1:0]] <= {bt_dt, asm_word};
        end else if (seq_wr) begin
            mem[ps_pm_add[AW-1:0]] <= ps_pm_dt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StBoot;
            bt_rdy       <= 1'b0;
            pm_boot_done <= 1'b0;
            pm_err       <= 1'b0;
            pm_ps_op     <= 32'h0;
            byte_idx     <= 2'd0;
            word_count   <= '0;
            asm_word     <= 24'h0;
        end else begin
            pm_err <= 1'b0;
            unique case (state)
                StBoot: begin
                    if (BOOT_WORDS == 0) begin
                        state        <= StRun;
                        pm_boot_done <= 1'b1;
                    end else if (!bt_rdy) begin
                        bt_rdy <= 1'b1;
                    end else if (bt_vld) begin
                        byte_idx <= byte_idx + 2'd1;
                        unique case (byte_idx)
                            2'd0: asm_word[7:0]   <= bt_dt;
                            2'd1: asm_word[15:8]  <= bt_dt;
                            2'd2: asm_word[23:16] <= bt_dt;
                            2'd3: begin
                                word_count <= word_count + CW'(1);
                                if (word_count == LAST_WORD) begin
                                    state        <= StRun;
                                    bt_rdy       <= 1'b0;
                                    pm_boot_done <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                StRun: begin
                    if (ps_pm_cslt) begin
                        if (!in_range) begin
                            pm_err <= 1'b1;
                            if (!ps_pm_wrb) begin
                                pm_ps_op <= 32'h0;
                            end
                        end else if (!ps_pm_wrb) begin
                            pm_ps_op <= mem[ps_pm_add[AW-1:0]];
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pm_mem_resp.sv
// Bench for pm_mem_resp: boot load, table-driven sequencer traffic, random traffic vs a
// memory model, mid-boot reset, and a zero-word-boot instance.
module tb_pm_mem_resp;

    localparam int unsigned Depth = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cslt, wrb, bt_vld, bt_rdy, done, err;
    logic [15:0] add;
    logic [31:0] dt, op;
    logic [7:0]  bt_dt;

    logic        rst0, cslt0, wrb0, bt_rdy0, done0, err0;
    logic        bt_vld0;
    logic [15:0] add0;
    logic [31:0] dt0, op0;
    logic [7:0]  bt_dt0;

    pm_mem_resp #(.PM_DEPTH(Depth), .BOOT_WORDS(2)) dut (
        .clk(clk), .rst(rst), .ps_pm_cslt(cslt), .ps_pm_wrb(wrb), .ps_pm_add(add),
        .ps_pm_dt(dt), .pm_ps_op(op), .bt_vld(bt_vld), .bt_dt(bt_dt), .bt_rdy(bt_rdy),
        .pm_boot_done(done), .pm_err(err)
    );

    pm_mem_resp #(.PM_DEPTH(Depth), .BOOT_WORDS(0)) dut0 (
        .clk(clk), .rst(rst0), .ps_pm_cslt(cslt0), .ps_pm_wrb(wrb0), .ps_pm_add(add0),
        .ps_pm_dt(dt0), .pm_ps_op(op0), .bt_vld(bt_vld0), .bt_dt(bt_dt0), .bt_rdy(bt_rdy0),
        .pm_boot_done(done0), .pm_err(err0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_iso = 1'b0;

    logic [31:0] ref_mem [logic [15:0]];
    logic [31:0] exp_op;
    logic        exp_err;

    typedef struct {
        logic        cslt;
        logic        wrb;
        logic [15:0] add;
        logic [31:0] dt;
        logic [31:0] op;
        logic        err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic took;
        int   n;
        bt_vld = 1'b1;
        bt_dt  = b;
        took   = 1'b0;
        n      = 0;
        while (!took && n < 8) begin
            took = bt_rdy;
            tick();
            n++;
            if (chk_iso) begin
                chk("boot_iso.op", op, 32'h0);
                chk("boot_iso.err", {31'b0, err}, 32'h0);
            end
        end
        bt_vld = 1'b0;
        if (!took) begin
            n_cmp++;
            n_bad++;
            $display("FAIL boot_handshake: byte %h not accepted, want accepted within 8 cycles", b);
        end
    endtask

    // Behavioural model: op holds unless a read happens; out-of-range reads return 0.
    task automatic seq_step(input logic c, input logic w, input logic [15:0] a,
                            input logic [31:0] d);
        cslt = c;
        wrb  = w;
        add  = a;
        dt   = d;
        if (c) begin
            if ({16'h0, a} >= Depth) begin
                if (!w) exp_op = 32'h0;
            end else if (w) begin
                ref_mem[a] = d;
            end else begin
                exp_op = ref_mem.exists(a) ? ref_mem[a] : 32'hx;
            end
        end
        exp_err = c && ({16'h0, a} >= Depth);
        tick();
        cslt = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] boot_a [8];
        boot_a = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h12345678, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0001, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h0005, 32'hA5A50001, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0005, 32'h0,        32'hA5A50001, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 16'h0100, 32'h0,        32'h00000000, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        32'h00000000, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 16'h0100, 32'h11111111, 32'h00000000, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 32'h0,        32'h12345678, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 16'h00FF, 32'hCAFEF00D, 32'h12345678, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 16'h00FF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 16'hFFFF, 32'h0,        32'h00000000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h01FF, 32'h0,        32'h00000000, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 16'h00FF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 16'h0005, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 16'h0005, 32'h0,        32'hA5A50001, 1'b0};

        rst = 1'b1; cslt = 1'b0; wrb = 1'b0; add = 16'h0; dt = 32'h0;
        bt_vld = 1'b0; bt_dt = 8'h0;
        rst0 = 1'b1; cslt0 = 1'b0; wrb0 = 1'b0; add0 = 16'h0; dt0 = 32'h0;
        bt_vld0 = 1'b0; bt_dt0 = 8'h0;
        exp_op = 32'h0; exp_err = 1'b0;

        repeat (3) tick();
        chk("rst.op", op, 32'h0);
        chk("rst.rdy", {31'b0, bt_rdy}, 32'h0);
        chk("rst.done", {31'b0, done}, 32'h0);
        chk("rst.err", {31'b0, err}, 32'h0);
        chk("rst0.done", {31'b0, done0}, 32'h0);

        // Boot two words; first byte is offered while bt_rdy is still low.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_byte(boot_a[i]);
            if (i == 6) chk("boot.done_early", {31'b0, done}, 32'h0);
        end
        chk("boot.rdy_fall", {31'b0, bt_rdy}, 32'h0);
        chk("boot.done_rise", {31'b0, done}, 32'h1);
        ref_mem[16'h0000] = 32'h12345678;
        ref_mem[16'h0001] = 32'hDEADBEEF;

        for (int i = 0; i < 15; i++) begin
            seq_step(tbl[i].cslt, tbl[i].wrb, tbl[i].add, tbl[i].dt);
            chk($sformatf("tbl[%0d].op", i), op, tbl[i].op);
            chk($sformatf("tbl[%0d].err", i), {31'b0, err}, {31'b0, tbl[i].err});
        end

        for (int i = 0; i < 400; i++) begin
            logic        c, w;
            logic [15:0] a;
            logic [31:0] d;
            c = ($urandom_range(0, 9) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                            : 16'($urandom_range(0, 15));
            d = $urandom;
            if (c && !w && ({16'h0, a} < Depth) && !ref_mem.exists(a)) w = 1'b1;
            seq_step(c, w, a, d);
            chk("rnd.op", op, exp_op);
            chk("rnd.err", {31'b0, err}, {31'b0, exp_err});
        end

        // Asynchronous reset mid-cycle, then a reload aborted two bytes into word 1.
        #2 rst = 1'b1;
        #1;
        chk("arst.op", op, 32'h0);
        chk("arst.done", {31'b0, done}, 32'h0);
        tick();
        rst = 1'b0;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hAA); send_byte(8'hBB);
        #2 rst = 1'b1;
        #1;
        chk("abort.rdy", {31'b0, bt_rdy}, 32'h0);
        chk("abort.done", {31'b0, done}, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        // Sequencer write held during boot must be ignored.
        cslt = 1'b1; wrb = 1'b1; add = 16'h00FF; dt = 32'hBAD0BAD0;
        chk_iso = 1'b1;
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'hF0); send_byte(8'hDE); send_byte(8'hBC); send_byte(8'h9A);
        chk_iso = 1'b0;
        cslt = 1'b0;
        chk("reload.done", {31'b0, done}, 32'h1);
        chk("reload.rdy", {31'b0, bt_rdy}, 32'h0);
        ref_mem[16'h0000] = 32'h01020304;
        ref_mem[16'h0001] = 32'h9ABCDEF0;
        exp_op = 32'h0;
        seq_step(1'b1, 1'b0, 16'h0000, 32'h0);
        chk("reload.rd0", op, 32'h01020304);
        seq_step(1'b1, 1'b0, 16'h0001, 32'h0);
        chk("reload.rd1", op, 32'h9ABCDEF0);
        seq_step(1'b1, 1'b0, 16'h00FF, 32'h0);
        chk("reload.rdFF_kept", op, 32'hCAFEF00D);
        seq_step(1'b1, 1'b0, 16'h0100, 32'h0);
        chk("reload.oor_op", op, 32'h0);
        chk("reload.oor_err", {31'b0, err}, 32'h1);
        tick();
        chk("reload.err_pulse_end", {31'b0, err}, 32'h0);

        // Zero-word boot: out-of-range read during the single boot cycle is ignored.
        rst0 = 1'b0;
        cslt0 = 1'b1; wrb0 = 1'b0; add0 = 16'h0100;
        chk("b0.done_boot", {31'b0, done0}, 32'h0);
        tick();
        chk("b0.done", {31'b0, done0}, 32'h1);
        chk("b0.rdy", {31'b0, bt_rdy0}, 32'h0);
        chk("b0.op_boot", op0, 32'h0);
        chk("b0.err_boot", {31'b0, err0}, 32'h0);
        tick();
        chk("b0.err_run", {31'b0, err0}, 32'h1);
        chk("b0.op_run", op0, 32'h0);
        cslt0 = 1'b0;
        tick();
        chk("b0.err_end", {31'b0, err0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
